// File: rtl/noc_endpoint.sv
// rtl/noc_endpoint.sv - NoC endpoint: packetizes PE words and depacketizes router packets
module noc_endpoint_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   // Callers only push when not full and only pop when not empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];
endmodule

module noc_endpoint #(
   parameter int           WIDTH_PACKAGE = 50,
   parameter logic [3:0]   NODE_LOC      = 4'b00_00,
   parameter int           FIFO_DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   input  logic [3:0]               tx_dest,
   input  logic [1:0]               tx_op,
   input  logic [39:0]              tx_data,
   output logic                     net_out_valid,
   input  logic                     net_out_ready,
   output logic [WIDTH_PACKAGE-1:0] net_out_pkt,
   input  logic                     net_in_valid,
   output logic                     net_in_ready,
   input  logic [WIDTH_PACKAGE-1:0] net_in_pkt,
   output logic                     rx_valid,
   input  logic                     rx_ready,
   output logic [3:0]               rx_src,
   output logic [1:0]               rx_op,
   output logic [39:0]              rx_data,
   output logic                     misroute_err,
   output logic [7:0]               drop_count
);
   localparam int RX_W = 46;

   logic                     tx_full, tx_empty, rx_full, rx_empty;
   logic [WIDTH_PACKAGE-1:0] tx_head;
   logic [RX_W-1:0]          rx_head;
   logic                     tx_push, tx_pop, rx_push, rx_pop;
   logic                     in_xfer, dest_match;

   // Readiness comes from registered occupancy only, so a full FIFO refuses
   // a push even in a cycle where it is also popping.
   assign tx_ready      = !reset && !tx_full;
   assign net_in_ready  = !reset && !rx_full;
   assign net_out_valid = !reset && !tx_empty;
   assign rx_valid      = !reset && !rx_empty;

   assign tx_push    = tx_valid && tx_ready;
   assign tx_pop     = net_out_valid && net_out_ready;
   assign in_xfer    = net_in_valid && net_in_ready;
   assign dest_match = (net_in_pkt[49:46] == NODE_LOC);
   assign rx_push    = in_xfer && dest_match;
   assign rx_pop     = rx_valid && rx_ready;

   noc_endpoint_fifo #(.WIDTH(WIDTH_PACKAGE), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (tx_push),
      .push_data ({tx_dest, NODE_LOC, tx_op, tx_data}),
      .pop       (tx_pop),
      .full      (tx_full),
      .empty     (tx_empty),
      .head      (tx_head)
   );

   noc_endpoint_fifo #(.WIDTH(RX_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rx_push),
      .push_data (net_in_pkt[RX_W-1:0]),
      .pop       (rx_pop),
      .full      (rx_full),
      .empty     (rx_empty),
      .head      (rx_head)
   );

   // Data outputs are forced to zero while empty so stale entries never leak.
   assign net_out_pkt = net_out_valid ? tx_head : '0;
   assign rx_src      = rx_valid ? rx_head[45:42] : '0;
   assign rx_op       = rx_valid ? rx_head[41:40] : '0;
   assign rx_data     = rx_valid ? rx_head[39:0]  : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         misroute_err <= 1'b0;
         drop_count   <= '0;
      end else if (in_xfer && !dest_match) begin
         misroute_err <= 1'b1;
         if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
   end
endmodule
